// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch timekeeping and RUN/PAUSED/ADJUST mode control for the 7-segment display.
// Optional: define STOPWATCH_DEBOUNCE_EN to add 2-flop sync + counter debounce on the buttons.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int BLINK_DIV = 25000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       blink,
  output logic       adjust,
  output logic       select,
  output logic       running
);

  // state     | meaning
  // ST_RUN    | time advances on every tick
  // ST_PAUSED | time and tick divider frozen
  // ST_ADJUST | time frozen, selected field stepped by the adjust divider
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  if (TICK_DIV < 1 || ADJ_DIV < 1 || BLINK_DIV < 1 || DB_CYCLES < 1) begin : g_param_chk
    $error("stopwatch_ctrl: divider parameters must be >= 1");
  end

  logic [1:0]    btn_lvl;   // {reset, pause}
  logic [1:0]    btn_prev;
  logic          pause_edge, reset_edge;
  logic [1:0]    state, state_nxt, saved, saved_nxt;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] adj_cnt;
  logic [BW-1:0] blink_cnt;
  logic [7:0]    sec, min, sec_nxt, min_nxt;
  logic          tick, adj_inc, sel_change;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  logic [1:0]    sync1, sync2, db_lvl;
  logic [DW-1:0] db_cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db_lvl <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_reset, btn_pause};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign btn_lvl = db_lvl;
`else
  logic [1:0] btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= '0;
    else     btn_q <= {btn_reset, btn_pause};
  end
  assign btn_lvl = btn_q;
`endif

  assign pause_edge = btn_lvl[0] & ~btn_prev[0];
  assign reset_edge = btn_lvl[1] & ~btn_prev[1];

  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] >= 4'd9) begin
      if (v[7:4] >= 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    case (state)
      ST_RUN: begin
        if (sw_adj) begin
          state_nxt = ST_ADJUST;
          saved_nxt = ST_RUN;
        end else if (pause_edge) begin
          state_nxt = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (sw_adj) begin
          state_nxt = ST_ADJUST;
          saved_nxt = ST_PAUSED;
        end else if (pause_edge) begin
          state_nxt = ST_RUN;
        end
      end
      ST_ADJUST: begin
        if (!sw_adj) state_nxt = saved;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign tick       = (state == ST_RUN) && (tick_cnt == TICK_LAST);
  assign sel_change = (sw_sel != select);
  // a select change restarts the adjust period, so no step lands on the old field
  assign adj_inc    = (state == ST_ADJUST) && !sel_change && (adj_cnt == ADJ_LAST);

  always_comb begin
    sec_nxt = sec;
    min_nxt = min;
    if (reset_edge) begin
      sec_nxt = 8'h00;
      min_nxt = 8'h00;
    end else if (tick) begin
      sec_nxt = bcd_inc60(sec);
      if (sec == 8'h59) min_nxt = bcd_inc60(min);
    end else if (adj_inc) begin
      if (select) min_nxt = bcd_inc60(min);
      else        sec_nxt = bcd_inc60(sec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      saved     <= ST_RUN;
      btn_prev  <= '0;
      tick_cnt  <= '0;
      adj_cnt   <= '0;
      blink_cnt <= '0;
      sec       <= 8'h00;
      min       <= 8'h00;
      blink     <= 1'b0;
      adjust    <= 1'b0;
      select    <= 1'b0;
      running   <= 1'b1;
    end else begin
      state    <= state_nxt;
      saved    <= saved_nxt;
      btn_prev <= btn_lvl;
      sec      <= sec_nxt;
      min      <= min_nxt;
      select   <= sw_sel;
      adjust   <= (state_nxt == ST_ADJUST);
      running  <= (state_nxt == ST_RUN);

      if (reset_edge || (state_nxt != state)) tick_cnt <= '0;
      else if (state == ST_RUN)               tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (state != ST_ADJUST || sel_change) adj_cnt <= '0;
      else                                  adj_cnt <= adj_inc ? '0 : adj_cnt + 1'b1;

      if (state_nxt != ST_ADJUST || state != ST_ADJUST) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign digit0 = min[7:4];
  assign digit1 = min[3:0];
  assign digit2 = sec[7:4];
  assign digit3 = sec[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (small dividers); expectations queued, checked by a monitor.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst, btn_pause, btn_reset, sw_adj, sw_sel;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       blink, adjust, select, running;

  typedef struct {
    string       name;
    logic [15:0] dig;
    int          blk;   // -1 = blink not checked
    logic        adj;
    logic        sel;
    logic        run;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic ok;

  int adj_ones  [7] = '{1, 1, 2, 2, 3, 3, 4};
  int adj_blink [7] = '{0, 0, 0, 1, 1, 1, 0};

  stopwatch_ctrl #(.TICK_DIV(4), .ADJ_DIV(2), .BLINK_DIV(3), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blink(blink), .adjust(adjust), .select(select), .running(running)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] dig, input int blk,
                            input logic adj, input logic sel, input logic run);
    exp_t e;
    e.name = name; e.dig = dig; e.blk = blk; e.adj = adj; e.sel = sel; e.run = run;
    sb.push_back(e);
  endtask

  // monitor: outputs are sampled on the falling edge after each queued expectation
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_chk++;
        ok = ({digit0, digit1, digit2, digit3} === mon_e.dig) && (adjust === mon_e.adj) &&
             (select === mon_e.sel) && (running === mon_e.run) &&
             ((mon_e.blk < 0) || (blink === mon_e.blk[0]));
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got digits=%h blink=%b adjust=%b select=%b running=%b, want digits=%h blink=%0d adjust=%b select=%b running=%b",
                   mon_e.name, {digit0, digit1, digit2, digit3}, blink, adjust, select, running,
                   mon_e.dig, mon_e.blk, mon_e.adj, mon_e.sel, mon_e.run);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    cyc(2);   expect_out("reset", 16'h0000, 0, 0, 0, 1);

    // free-running count
    rst = 1'b0;
    cyc(239); expect_out("count_0059", 16'h0059, 0, 0, 0, 1);
    cyc(1);   expect_out("count_0100", 16'h0100, 0, 0, 0, 1);

    // pause edge lands on the third tick
    rst = 1'b1;
    cyc(1);   expect_out("rst_pulse", 16'h0000, 0, 0, 0, 1);
    rst = 1'b0;
    cyc(10);  btn_pause = 1'b1;
    cyc(1);   expect_out("pre_pause", 16'h0002, 0, 0, 0, 1);
    cyc(1);   expect_out("pause_with_tick", 16'h0003, 0, 0, 0, 0);
    btn_pause = 1'b0;
    cyc(100); expect_out("pause_hold", 16'h0003, 0, 0, 0, 0);
    btn_pause = 1'b1;
    cyc(1);   expect_out("resume_latency", 16'h0003, 0, 0, 0, 0);
    btn_pause = 1'b0;
    cyc(1);   expect_out("resume", 16'h0003, 0, 0, 0, 1);
    cyc(3);   expect_out("resume_div", 16'h0003, 0, 0, 0, 1);
    cyc(1);   expect_out("resume_tick", 16'h0004, 0, 0, 0, 1);

    // reset button edge on the same cycle as the 00:07 -> 00:08 tick
    cyc(14);  expect_out("pre_collision", 16'h0007, 0, 0, 0, 1);
    btn_reset = 1'b1;
    cyc(1);   expect_out("collision_lat", 16'h0007, 0, 0, 0, 1);
    cyc(1);   expect_out("collision_reset", 16'h0000, 0, 0, 0, 1);
    btn_reset = 1'b0;
    cyc(3);   expect_out("post_coll_div", 16'h0000, 0, 0, 0, 1);
    cyc(1);   expect_out("post_coll_tick", 16'h0001, 0, 0, 0, 1);

    // adjust seconds from RUN
    sw_adj = 1'b1; sw_sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      expect_out("adj_seq", 16'(adj_ones[i]), adj_blink[i], 1, 0, 0);
    end
    cyc(14);  expect_out("adj_sec_plus10", 16'h0011, 0, 1, 0, 0);
    cyc(96);  expect_out("adj_sec_59", 16'h0059, -1, 1, 0, 0);
    sw_sel = 1'b1;
    cyc(1);   expect_out("sel_follow", 16'h0059, -1, 1, 1, 0);
    cyc(1);   expect_out("sel_wait", 16'h0059, -1, 1, 1, 0);
    cyc(1);   expect_out("adj_min_only", 16'h0159, -1, 1, 1, 0);
    cyc(116); expect_out("adj_min_59", 16'h5959, -1, 1, 1, 0);
    cyc(1);   expect_out("adj_mid_period", 16'h5959, -1, 1, 1, 0);
    sw_sel = 1'b0;
    cyc(1);   expect_out("sel_change_clear", 16'h5959, -1, 1, 0, 0);
    cyc(1);   expect_out("sel_change_wait", 16'h5959, -1, 1, 0, 0);
    cyc(1);   expect_out("sec_wrap_nocarry", 16'h5900, -1, 1, 0, 0);
    cyc(116); expect_out("preload_5958", 16'h5958, -1, 1, 0, 0);
    sw_adj = 1'b0;
    cyc(1);   expect_out("adj_exit_run", 16'h5958, 0, 0, 0, 1);
    cyc(3);   expect_out("wrap_div", 16'h5958, 0, 0, 0, 1);
    cyc(1);   expect_out("wrap_5959", 16'h5959, 0, 0, 0, 1);
    cyc(3);   expect_out("wrap_hold", 16'h5959, 0, 0, 0, 1);
    cyc(1);   expect_out("wrap_0000", 16'h0000, 0, 0, 0, 1);

    // adjust from PAUSED up to 12:34, then rst
    btn_pause = 1'b1;
    cyc(1);   btn_pause = 1'b0;
    cyc(1);   expect_out("pause2", 16'h0000, 0, 0, 0, 0);
    sw_adj = 1'b1; sw_sel = 1'b1;
    cyc(1);   expect_out("adj_from_pause", 16'h0000, 0, 1, 1, 0);
    cyc(24);  expect_out("adj_min_12", 16'h1200, -1, 1, 1, 0);
    sw_sel = 1'b0;
    cyc(69);  expect_out("adj_1234", 16'h1234, -1, 1, 0, 0);
    rst = 1'b1;
    cyc(1);   expect_out("rst_in_adjust", 16'h0000, 0, 0, 0, 1);
    rst = 1'b0; sw_adj = 1'b0;

    // pause edge ignored in ADJUST; exit restores PAUSED
    btn_pause = 1'b1;
    cyc(1);   btn_pause = 1'b0;
    cyc(1);   expect_out("pause3", 16'h0000, 0, 0, 0, 0);
    sw_adj = 1'b1;
    cyc(1);   expect_out("adj3", 16'h0000, 0, 1, 0, 0);
    btn_pause = 1'b1;
    cyc(1);   btn_pause = 1'b0;
    cyc(1);   expect_out("adj_pause_ignored", 16'h0001, 0, 1, 0, 0);
    sw_adj = 1'b0;
    cyc(1);   expect_out("restore_paused", 16'h0001, 0, 0, 0, 0);
    cyc(8);   expect_out("paused_frozen", 16'h0001, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
